// File: rtl/ahbl_audio_fifo.sv
// AHB-Lite slave buffering I2S receive samples in a circular FIFO.
// Exposes DATA/STATUS/CTRL/IE registers and a registered level/overflow interrupt.
module ahbl_audio_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic          HWRITE,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    input  logic          smp_valid,
    input  logic [DW-1:0] smp_data,
    output logic          irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_IE     = 2'd3;

    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    logic [1:0]    dp_addr_q,  dp_addr_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   level_q,    level_d;
    logic          ovf_q,      ovf_d;
    logic          en_q,       en_d;
    logic [7:0]    thresh_q,   thresh_d;
    logic          thr_ie_q,   thr_ie_d;
    logic          ovf_ie_q,   ovf_ie_d;
    logic          irq_q,      irq_d;

    logic [DW-1:0] mem [DEPTH];

    logic        empty, full, thr_hit;
    logic        rd_phase, wr_phase;
    logic        wr_ctrl, wr_status, wr_ie;
    logic        clr, push_req, push, pop, ovf_set;
    logic [8:0]  level9;
    logic [31:0] status_word, ctrl_word, ie_word, data_word;

    logic unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0],
                           HWDATA[31:19], HWDATA[17:16], HWDATA[7:2]};

    assign HREADYOUT = 1'b1;
    assign irq       = irq_q;

    assign empty    = (level_q == '0);
    assign full     = (level_q == FULL_LVL);
    assign rd_phase = dp_valid_q & ~dp_write_q;
    assign wr_phase = dp_valid_q &  dp_write_q;

    assign wr_ctrl   = wr_phase & (dp_addr_q == A_CTRL);
    assign wr_status = wr_phase & (dp_addr_q == A_STATUS);
    assign wr_ie     = wr_phase & (dp_addr_q == A_IE);

    // A flush wins over anything else happening to the FIFO in the same cycle.
    assign clr      = wr_ctrl & HWDATA[1];
    assign pop      = rd_phase & (dp_addr_q == A_DATA) & ~empty & ~clr;
    assign push_req = smp_valid & en_q & ~clr;
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    always_comb begin
        level9 = '0;
        level9[AW:0] = level_q;
    end

    assign thr_hit = (level9 >= {1'b0, thresh_q});

    always_comb begin
        status_word        = '0;
        status_word[8:0]   = level9;
        status_word[16]    = empty;
        status_word[17]    = full;
        status_word[18]    = ovf_q;
        status_word[19]    = thr_hit;
        ctrl_word          = '0;
        ctrl_word[0]       = en_q;
        ctrl_word[15:8]    = thresh_q;
        ie_word            = '0;
        ie_word[0]         = thr_ie_q;
        ie_word[1]         = ovf_ie_q;
        data_word          = '0;
        if (!empty) begin
            data_word[DW-1:0] = mem[rd_ptr_q];
        end
    end

    always_comb begin
        HRDATA = '0;
        if (rd_phase) begin
            case (dp_addr_q)
                A_DATA:   HRDATA = data_word;
                A_STATUS: HRDATA = status_word;
                A_CTRL:   HRDATA = ctrl_word;
                default:  HRDATA = ie_word;
            endcase
        end
    end

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        en_d       = en_q;
        thresh_d   = thresh_q;
        thr_ie_d   = thr_ie_q;
        ovf_ie_d   = ovf_ie_q;
        irq_d      = (thr_ie_q & thr_hit) | (ovf_ie_q & ovf_q);

        if (HREADY) begin
            dp_valid_d = HSEL & HTRANS[1];
            dp_write_d = HWRITE;
            dp_addr_d  = HADDR[3:2];
        end

        if (wr_ctrl) begin
            en_d     = HWDATA[0];
            thresh_d = HWDATA[15:8];
        end
        if (wr_ie) begin
            thr_ie_d = HWDATA[0];
            ovf_ie_d = HWDATA[1];
        end

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            // A new overflow in the same cycle as a W1C keeps the flag set.
            if (ovf_set)
                ovf_d = 1'b1;
            else if (wr_status & HWDATA[18])
                ovf_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            en_q       <= 1'b0;
            thresh_q   <= 8'd8;
            thr_ie_q   <= 1'b0;
            ovf_ie_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            en_q       <= en_d;
            thresh_q   <= thresh_d;
            thr_ie_q   <= thr_ie_d;
            ovf_ie_q   <= ovf_ie_d;
            irq_q      <= irq_d;
        end
    end

    // Sample storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr_q] <= smp_data;
        end
    end

endmodule

// File: tb/tb_ahbl_audio_fifo.sv
// Scoreboard bench for ahbl_audio_fifo: a queue model predicts DATA reads and STATUS.
module tb_ahbl_audio_fifo;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL, HREADY, HWRITE;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        smp_valid;
    logic [31:0] smp_data;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    bit          en_m;
    bit          ovf_m;
    int          thresh_m;

    ahbl_audio_fifo #(.DEPTH(16), .DW(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
        .HWRITE(HWRITE), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
        .smp_valid(smp_valid), .smp_data(smp_data), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int lvl;
        lvl = q.size();
        s = '0;
        s[8:0] = 9'(lvl);
        s[16]  = (lvl == 0);
        s[17]  = (lvl == 16);
        s[18]  = ovf_m;
        s[19]  = (lvl >= thresh_m);
        return s;
    endfunction

    function automatic logic [31:0] model_pop();
        if (q.size() == 0) return 32'h0;
        return q.pop_front();
    endfunction

    function automatic void model_push(input logic [31:0] d);
        if (!en_m) return;
        if (q.size() < 16) q.push_back(d);
        else ovf_m = 1'b1;
    endfunction

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                             input bit wp, input logic [31:0] pd);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a};
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = d;
        smp_valid = wp; smp_data = pd;
        @(posedge HCLK); #1;
        smp_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d,
                            input bit wp, input logic [31:0] pd);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a};
        @(posedge HCLK); #1;
        bus_idle();
        smp_valid = wp; smp_data = pd;
        @(negedge HCLK);
        d = HRDATA;
        @(posedge HCLK); #1;
        smp_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        @(posedge HCLK); #1;
        smp_valid = 1'b1; smp_data = d;
        model_push(d);
        @(posedge HCLK); #1;
        smp_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        tests++;
        if (HRDATA !== 32'h0) begin fails++; $display("FAIL rst_hrdata: got %h expected %h", HRDATA, 32'h0); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b expected 0", irq); end
        tests++;
        if (HREADYOUT !== 1'b1) begin fails++; $display("FAIL rst_hreadyout: got %b expected 1", HREADYOUT); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        bus_read(4'h4, d, 0, 0);
        tests++;
        if (d !== 32'h0001_0000) begin fails++; $display("FAIL rst_status: got %h expected %h", d, 32'h0001_0000); end
        bus_read(4'h8, d, 0, 0);
        tests++;
        if (d !== 32'h0000_0800) begin fails++; $display("FAIL rst_ctrl: got %h expected %h", d, 32'h0000_0800); end
        bus_read(4'hC, d, 0, 0);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL rst_ie: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] d, e;
        bus_write(4'h8, 32'h0000_0801, 0, 0);
        en_m = 1'b1; thresh_m = 8;
        for (int i = 0; i < 16; i++) push(32'h11 + i);
        bus_read(4'h4, d, 0, 0);
        e = exp_status();
        tests++;
        if (d !== e) begin fails++; $display("FAIL fill_status: got %h expected %h", d, e); end
        for (int i = 0; i < 16; i++) begin
            bus_read(4'h0, d, 0, 0);
            e = model_pop();
            tests++;
            if (d !== e) begin fails++; $display("FAIL drain_data[%0d]: got %h expected %h", i, d, e); end
        end
        bus_read(4'h4, d, 0, 0);
        e = exp_status();
        tests++;
        if (d !== e) begin fails++; $display("FAIL drain_status: got %h expected %h", d, e); end
        bus_read(4'h0, d, 0, 0);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL empty_read: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        for (int i = 0; i < 16; i++) push(32'h31 + i);
        push(32'hAA);
        bus_read(4'h4, d, 0, 0);
        e = exp_status();
        tests++;
        if (d !== e) begin fails++; $display("FAIL ovf_status: got %h expected %h", d, e); end
        for (int i = 0; i < 16; i++) begin
            bus_read(4'h0, d, 0, 0);
            e = model_pop();
            tests++;
            if (d !== e) begin fails++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, d, e); end
        end
        bus_write(4'h4, 32'h0004_0000, 0, 0);
        ovf_m = 1'b0;
        bus_read(4'h4, d, 0, 0);
        e = exp_status();
        tests++;
        if (d !== e) begin fails++; $display("FAIL ovf_clear: got %h expected %h", d, e); end
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] d, e;
        for (int i = 0; i < 16; i++) push(32'h61 + i);
        bus_read(4'h0, d, 1, 32'h55);
        e = model_pop();
        model_push(32'h55);
        tests++;
        if (d !== e) begin fails++; $display("FAIL sim_full_data: got %h expected %h", d, e); end
        bus_read(4'h4, d, 0, 0);
        e = exp_status();
        tests++;
        if (d !== e) begin fails++; $display("FAIL sim_full_status: got %h expected %h", d, e); end
        for (int i = 0; i < 16; i++) begin
            bus_read(4'h0, d, 0, 0);
            e = model_pop();
            tests++;
            if (d !== e) begin fails++; $display("FAIL sim_drain[%0d]: got %h expected %h", i, d, e); end
        end
        bus_read(4'h0, d, 1, 32'h66);
        e = model_pop();
        model_push(32'h66);
        tests++;
        if (d !== e) begin fails++; $display("FAIL sim_empty_data: got %h expected %h", d, e); end
        bus_read(4'h4, d, 0, 0);
        e = exp_status();
        tests++;
        if (d !== e) begin fails++; $display("FAIL sim_empty_status: got %h expected %h", d, e); end
        bus_read(4'h0, d, 0, 0);
        e = model_pop();
        tests++;
        if (d !== e) begin fails++; $display("FAIL sim_empty_drain: got %h expected %h", d, e); end
    endtask

    task automatic test_irq();
        logic [31:0] d, e;
        bus_write(4'h8, 32'h0000_0401, 0, 0);
        thresh_m = 4;
        bus_write(4'hC, 32'h0000_0001, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push(32'h71 + i);
            @(posedge HCLK); #1;
            tests++;
            if (irq !== 1'b0) begin fails++; $display("FAIL irq_below[%0d]: got %b expected 0", i, irq); end
        end
        push(32'h74);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_lag: got %b expected 0", irq); end
        @(posedge HCLK); #1;
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b expected 1", irq); end
        bus_read(4'h0, d, 0, 0);
        e = model_pop();
        tests++;
        if (d !== e) begin fails++; $display("FAIL irq_pop_data: got %h expected %h", d, e); end
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_hold: got %b expected 1", irq); end
        @(posedge HCLK); #1;
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_flush();
        logic [31:0] d, e;
        for (int i = 0; i < 4; i++) push(32'h81 + i);
        bus_read(4'h4, d, 0, 0);
        e = exp_status();
        tests++;
        if (d !== e) begin fails++; $display("FAIL flush_pre_status: got %h expected %h", d, e); end
        bus_write(4'h8, 32'h0000_0803, 1, 32'h77);
        q.delete(); ovf_m = 1'b0; en_m = 1'b1; thresh_m = 8;
        bus_read(4'h4, d, 0, 0);
        e = exp_status();
        tests++;
        if (d !== e) begin fails++; $display("FAIL flush_status: got %h expected %h", d, e); end
        bus_read(4'h8, d, 0, 0);
        tests++;
        if (d !== 32'h0000_0801) begin fails++; $display("FAIL flush_ctrl: got %h expected %h", d, 32'h0000_0801); end
        bus_read(4'h0, d, 0, 0);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL flush_data: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] d;
        for (int i = 0; i < 5; i++) push(32'h91 + i);
        bus_write(4'hC, 32'h0000_0003, 0, 0);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0;
        @(posedge HCLK); #1;
        bus_idle();
        #2 HRESET = 1'b1;
        #1;
        tests++;
        if (HRDATA !== 32'h0) begin fails++; $display("FAIL midrst_hrdata: got %h expected %h", HRDATA, 32'h0); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        q.delete(); ovf_m = 1'b0; en_m = 1'b0; thresh_m = 8;
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        bus_read(4'h4, d, 0, 0);
        tests++;
        if (d !== exp_status()) begin fails++; $display("FAIL midrst_status: got %h expected %h", d, exp_status()); end
        bus_read(4'h8, d, 0, 0);
        tests++;
        if (d !== 32'h0000_0800) begin fails++; $display("FAIL midrst_ctrl: got %h expected %h", d, 32'h0000_0800); end
        bus_read(4'hC, d, 0, 0);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL midrst_ie: got %h expected %h", d, 32'h0); end
    endtask

    initial begin
        HRESET = 1'b1; HREADY = 1'b1; HSIZE = 3'b010; HWDATA = '0;
        smp_valid = 1'b0; smp_data = '0;
        bus_idle();
        en_m = 1'b0; ovf_m = 1'b0; thresh_m = 8;
        #12;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul_push_pop();
        test_irq();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
